// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: parses 16-bit SPI words into frames of the form
//   {BLOCK_ADDR,8'h00}, {size,cmd}, size data words, checksum, packet number.
// Data words are forwarded as they arrive; the frame end is reported as
// frame_ok (checksum matched) or frame_err (checksum / inter-word timeout).
//
// Handshake: in_request is a one-cycle valid strobe qualifying in_data; this
// block is always ready, so every strobe is consumed. out_request is a
// one-cycle valid strobe qualifying out_data; the consumer is always ready.
// All outputs are registered and respond one cycle after the causing strobe.
module spi_frame_receiver #(
  parameter logic [7:0]  BLOCK_ADDR = 8'hAB,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_request,
  output logic [15:0] out_data,
  output logic        out_request,
  output logic [7:0]  out_cmd,
  output logic        frame_start,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] pkt_num,
  output logic [2:0]  dbg_state
);

  localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
  localparam logic [15:0]   ADDR_WORD = {BLOCK_ADDR, 8'h00};

  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  // S_* names the word the receiver expects next.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_NUM  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   sum_q, sum_d;
  logic [7:0]    remain_q, remain_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          match_q, match_d;

  logic [15:0]   out_data_q, out_data_d;
  logic          out_request_q, out_request_d;
  logic [7:0]    out_cmd_q, out_cmd_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [15:0]   pkt_num_q, pkt_num_d;

  // A word arriving in the limit cycle wins over the timeout.
  logic timeout_hit;
  assign timeout_hit = (state_q != S_IDLE) && !in_request && (tmo_q == TMO_LIMIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advance one step per accepted word, abort on timeout.
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = S_IDLE;
    end else if (in_request) begin
      case (state_q)
        S_IDLE:  if (in_data == ADDR_WORD) state_d = S_HDR;
        S_HDR:   state_d = (in_data[15:8] != 8'd0) ? S_DATA : S_CSUM;
        S_DATA:  if (remain_q == 8'd1) state_d = S_CSUM;
        S_CSUM:  state_d = S_NUM;
        S_NUM:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values: pulses default low, held values default to hold.
  always_comb begin
    sum_d         = sum_q;
    remain_d      = remain_q;
    match_d       = match_q;
    out_data_d    = out_data_q;
    out_request_d = 1'b0;
    out_cmd_d     = out_cmd_q;
    frame_start_d = 1'b0;
    frame_ok_d    = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    pkt_num_d     = pkt_num_q;

    // Idle-gap counter only runs while a frame is open.
    if ((state_q == S_IDLE) || in_request || timeout_hit) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TMO;
    end else if (in_request) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == ADDR_WORD) begin
            sum_d = in_data;
          end
        end
        S_HDR: begin
          remain_d      = in_data[15:8];
          out_cmd_d     = in_data[7:0];
          sum_d         = sum_q + in_data;
          frame_start_d = 1'b1;
          err_code_d    = 2'b00;
        end
        S_DATA: begin
          sum_d         = sum_q + in_data;
          out_data_d    = in_data;
          out_request_d = 1'b1;
          remain_d      = remain_q - 8'd1;
        end
        S_CSUM: begin
          match_d = (in_data == sum_q);
        end
        S_NUM: begin
          if (match_q) begin
            pkt_num_d  = in_data;
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q         <= '0;
      remain_q      <= '0;
      tmo_q         <= '0;
      match_q       <= 1'b0;
      out_data_q    <= '0;
      out_request_q <= 1'b0;
      out_cmd_q     <= '0;
      frame_start_q <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
      pkt_num_q     <= '0;
    end else begin
      sum_q         <= sum_d;
      remain_q      <= remain_d;
      tmo_q         <= tmo_d;
      match_q       <= match_d;
      out_data_q    <= out_data_d;
      out_request_q <= out_request_d;
      out_cmd_q     <= out_cmd_d;
      frame_start_q <= frame_start_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      pkt_num_q     <= pkt_num_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_request = out_request_q;
  assign out_cmd     = out_cmd_q;
  assign frame_start = frame_start_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign pkt_num     = pkt_num_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: directed frames plus randomized frames with
// random gaps, checked against a frame-position reference model.
module tb_spi_frame_receiver;

  localparam int          TMO    = 40;
  localparam logic [15:0] ADDR_W = 16'hAB00;

  localparam logic [3:0] EV_START = 4'd1;
  localparam logic [3:0] EV_REQ   = 4'd2;
  localparam logic [3:0] EV_OK    = 4'd3;
  localparam logic [3:0] EV_ERR   = 4'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = 16'h0000;
  logic        in_request = 1'b0;
  logic [15:0] out_data;
  logic        out_request;
  logic [7:0]  out_cmd;
  logic        frame_start;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] pkt_num;
  logic [2:0]  dbg_state;

  spi_frame_receiver #(.BLOCK_ADDR(8'hAB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_request(in_request),
    .out_data(out_data), .out_request(out_request), .out_cmd(out_cmd),
    .frame_start(frame_start), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .pkt_num(pkt_num), .dbg_state(dbg_state)
  );

  // Clock and edge counter (cyc = index of the most recent rising edge).
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: events are {edge index, kind, data}.
  int total = 0;
  int bad = 0;
  logic [51:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [51:0] mk_ev(input int e, input logic [3:0] k, input logic [15:0] d);
    return {32'(e), k, d};
  endfunction

  // Reference model: position of the next word inside the current frame.
  bit          m_active = 0;
  int          m_pos = 0;
  int          m_size = 0;
  int          m_quiet = 0;
  int          m_last_edge = 0;
  logic [15:0] m_sum = 0;
  logic [15:0] m_pkt = 0;
  logic [7:0]  m_cmd = 0;
  logic [1:0]  m_err = 0;
  bit          m_match = 0;

  task automatic model_reset();
    m_active = 0; m_quiet = 0; m_pkt = 0; m_cmd = 0; m_err = 0;
  endtask

  task automatic model_word(input logic [15:0] w, input int e);
    m_quiet = 0;
    m_last_edge = e;
    if (!m_active) begin
      if (w == ADDR_W) begin
        m_active = 1; m_pos = 1; m_sum = w;
      end
    end else if (m_pos == 1) begin
      m_size = int'(w[15:8]);
      m_cmd = w[7:0];
      m_err = 2'b00;
      m_sum = m_sum + w;
      exp_q.push_back(mk_ev(e, EV_START, {8'h00, w[7:0]}));
      m_pos = 2;
    end else if (m_pos < m_size + 2) begin
      m_sum = m_sum + w;
      exp_q.push_back(mk_ev(e, EV_REQ, w));
      m_pos++;
    end else if (m_pos == m_size + 2) begin
      m_match = (w == m_sum);
      m_pos++;
    end else begin
      if (m_match) begin
        m_pkt = w;
        exp_q.push_back(mk_ev(e, EV_OK, w));
      end else begin
        m_err = 2'b01;
        exp_q.push_back(mk_ev(e, EV_ERR, 16'h0001));
      end
      m_active = 0;
    end
  endtask

  task automatic model_quiet(input int n);
    m_quiet += n;
    if (m_active && m_quiet > TMO) begin
      exp_q.push_back(mk_ev(m_last_edge + TMO + 1, EV_ERR, 16'h0002));
      m_err = 2'b10;
      m_active = 0;
    end
  endtask

  // Driver tasks: entered and left at posedge+2.
  task automatic send_word(input logic [15:0] w);
    in_data = w;
    in_request = 1'b1;
    model_word(w, cyc + 1);
    @(posedge clk); #2;
    in_request = 1'b0;
    in_data = 16'($urandom);
  endtask

  task automatic idle(input int n);
    model_quiet(n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic send_list(input logic [15:0] ws[$]);
    foreach (ws[i]) send_word(ws[i]);
  endtask

  task automatic check_levels(input string tag);
    chk({tag, "_cmd"}, out_cmd, m_cmd);
    chk({tag, "_err_code"}, err_code, m_err);
    chk({tag, "_pkt_num"}, pkt_num, m_pkt);
  endtask

  // Monitor: turn output pulses into events and match them in order.
  task automatic got_ev(input logic [51:0] ev);
    if (exp_q.size() == 0) chk("unexpected_event", ev, 52'h0);
    else chk("event", ev, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("ok_err_exclusive", frame_ok & frame_err, 1'b0);
      if (frame_start) got_ev(mk_ev(cyc, EV_START, {8'h00, out_cmd}));
      if (out_request) got_ev(mk_ev(cyc, EV_REQ, out_data));
      if (frame_ok)    got_ev(mk_ev(cyc, EV_OK, pkt_num));
      if (frame_err)   got_ev(mk_ev(cyc, EV_ERR, {14'h0, err_code}));
    end
  end

  // Watchdog: every wait is bounded, this only guards against a stuck bench.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, exp_q=%0d", exp_q.size());
    $fatal(1);
  end

  logic [15:0] t1[$] = '{16'hAB00, 16'h08A2, 16'hFFA1, 16'h0001, 16'hFFA3, 16'h0002,
                         16'hFFA3, 16'hAB45, 16'hFFA3, 16'hFFA1, 16'h5D15, 16'h0000};
  logic [15:0] t2[$] = '{16'hAB00, 16'h08A2, 16'hFFA1, 16'h0001, 16'hFFA3, 16'h0002,
                         16'hFFA3, 16'hAB45, 16'hFFA3, 16'hFFA1, 16'h5D16, 16'h0005};
  logic [15:0] t3[$] = '{16'hAC00, 16'h08A2, 16'hFFA1, 16'h0001, 16'hFFA3, 16'h0002,
                         16'hFFA3, 16'hAB45, 16'hFFA3, 16'hFFA1, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] t4[$] = '{16'hAB00, 16'h00A5, 16'hABA5, 16'h0007};

  initial begin
    logic [15:0] fw[$];
    logic [15:0] sum;
    logic [15:0] w;
    int sz;
    int r;

    // Reset
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    chk("reset_outputs", {out_data, out_request, out_cmd, frame_start, frame_ok,
                          frame_err, err_code, pkt_num}, 0);
    chk("reset_state", dbg_state, 3'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    idle(2);

    // Reference frame
    send_list(t1); idle(2);
    chk("t1_cmd", out_cmd, 8'hA2);
    chk("t1_pkt", pkt_num, 16'h0000);
    check_levels("t1");

    // Size-zero frame
    send_list(t4); idle(2);
    chk("t4_pkt", pkt_num, 16'h0007);
    check_levels("t4");

    // Bad checksum: pkt_num keeps 0007
    send_list(t2); idle(2);
    chk("t2_err_code", err_code, 2'b01);
    chk("t2_pkt", pkt_num, 16'h0007);
    check_levels("t2");

    // Foreign address: nothing happens
    send_list(t3); idle(2);
    chk("t3_state_idle", dbg_state, 3'd0);
    check_levels("t3");

    // Timeout after one data word, then a valid frame
    send_word(16'hAB00); send_word(16'h08A2); send_word(16'hFFA1);
    idle(TMO + 5);
    chk("t5_err_code", err_code, 2'b10);
    send_list(t1); idle(2);
    check_levels("t5");

    // Words arriving exactly at the limit are processed
    send_word(16'hAB00); idle(TMO);
    send_word(16'h01A7); idle(TMO);
    send_word(16'h1234); idle(TMO);
    send_word(16'hBEDB); idle(TMO);
    send_word(16'h0042); idle(2);
    chk("limit_pkt", pkt_num, 16'h0042);
    check_levels("limit");

    // Reset mid-frame after the 5th word
    send_list('{16'hAB00, 16'h08A2, 16'hFFA1, 16'h0001, 16'hFFA3});
    idle(1);
    rst = 1'b1;
    model_reset();
    #3;
    chk("midreset_outputs", {out_data, out_request, out_cmd, frame_start, frame_ok,
                             frame_err, err_code, pkt_num}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    idle(2);
    send_list(t1); idle(2);
    check_levels("t6");

    // Randomized frames with junk words and random gaps
    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        w = 16'($urandom);
        if (w == ADDR_W) w = w ^ 16'h0001;
        send_word(w);
        idle($urandom_range(0, 2));
      end
      fw.delete();
      sz = $urandom_range(0, 6);
      fw.push_back(ADDR_W);
      fw.push_back({8'(sz), 8'($urandom)});
      for (int k = 0; k < sz; k++) fw.push_back(16'($urandom));
      sum = 16'h0000;
      foreach (fw[k]) sum = sum + fw[k];
      if ($urandom_range(0, 3) == 0) sum = sum ^ (16'h1 << $urandom_range(0, 15));
      fw.push_back(sum);
      fw.push_back(16'($urandom));
      foreach (fw[k]) begin
        send_word(fw[k]);
        r = $urandom_range(0, 19);
        if (r < 14)       idle(0);
        else if (r < 18)  idle($urandom_range(1, 3));
        else if (r == 18) idle(TMO);
        else              idle(TMO + 1 + $urandom_range(0, 3));
      end
      idle(2);
      check_levels("rand");
    end

    idle(TMO + 5);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
